// File: rtl/mem_access_unit.sv
// Load/store unit between a core and a single-beat memory port.
// Aligns addresses, positions store lanes, extends load results and flags faults.
module mem_access_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int BE_W   = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [BE_W-1:0]   mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_fault
);
  localparam int OFF_W = $clog2(BE_W);

  generate
    if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
      $error("mem_access_unit: XLEN must be 32 or 64");
    end
    if (BE_W != XLEN / 8) begin : g_bad_be_w
      $error("mem_access_unit: BE_W must equal XLEN/8");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_accept;
  logic   w_capture;

  // Request decode, evaluated on the incoming fields in IDLE.
  logic [OFF_W-1:0]  w_offset;
  logic [1:0]        w_size;
  logic              w_misaligned;
  logic              w_illegal;
  logic              w_fault;
  logic [BE_W-1:0]   w_mask;
  logic [XLEN-1:0]   w_dmask;
  logic [BE_W-1:0]   w_be;
  logic [XLEN-1:0]   w_wdata;
  logic [ADDR_W-1:0] w_maddr;

  assign w_offset = req_addr[OFF_W-1:0];
  assign w_size   = req_funct3[1:0];

  always_comb begin
    // NOTE: every variable written in a combinational block gets a default first so no latch is inferred.
    w_misaligned = 1'b0;
    w_mask       = '0;
    case (w_size)
      2'd0: begin
        w_misaligned = 1'b0;
        w_mask       = BE_W'(8'h01);
      end
      2'd1: begin
        w_misaligned = req_addr[0];
        w_mask       = BE_W'(8'h03);
      end
      2'd2: begin
        w_misaligned = |req_addr[1:0];
        w_mask       = BE_W'(8'h0F);
      end
      default: begin
        w_misaligned = |req_addr[2:0];
        w_mask       = BE_W'(8'hFF);
      end
    endcase
  end

  assign w_illegal = (req_funct3 == 3'b111)
                   || ((XLEN == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110)))
                   || (req_store && req_funct3[2]);
  assign w_fault   = w_misaligned | w_illegal;

  always_comb begin
    w_dmask = '0;
    for (int i = 0; i < BE_W; i++) begin
      w_dmask[8*i +: 8] = {8{w_mask[i]}};
    end
  end

  assign w_be    = w_mask << w_offset;
  assign w_wdata = (req_wdata & w_dmask) << {w_offset, 3'b000};
  assign w_maddr = req_addr & ~ADDR_W'(BE_W - 1);

  // Registered transaction context.
  logic              r_store;
  logic [2:0]        r_funct3;
  logic [OFF_W-1:0]  r_offset;
  logic              r_fault;
  logic [XLEN-1:0]   r_rdata;
  logic              r_mem_we;
  logic [BE_W-1:0]   r_mem_be;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [XLEN-1:0]   r_mem_wdata;

  logic [XLEN-1:0]   w_shifted;
  logic [XLEN-1:0]   w_load;

  assign w_shifted = mem_rdata >> {r_offset, 3'b000};

  // Size casts of a signed operand sign-extend; of an unsigned operand zero-extend.
  always_comb begin
    w_load = w_shifted;
    case (r_funct3)
      3'b000:  w_load = XLEN'($signed(w_shifted[7:0]));
      3'b001:  w_load = XLEN'($signed(w_shifted[15:0]));
      3'b010:  w_load = XLEN'($signed(w_shifted[31:0]));
      3'b100:  w_load = XLEN'(w_shifted[7:0]);
      3'b101:  w_load = XLEN'(w_shifted[15:0]);
      3'b110:  w_load = XLEN'(w_shifted[31:0]);
      default: w_load = w_shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_capture     = 1'b0;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    rsp_valid     = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = w_fault ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_store     <= 1'b0;
      r_funct3    <= '0;
      r_offset    <= '0;
      r_fault     <= 1'b0;
      r_rdata     <= '0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      if (w_accept) begin
        r_store  <= req_store;
        r_funct3 <= req_funct3;
        r_offset <= w_offset;
        r_fault  <= w_fault;
        r_rdata  <= '0;
        // A faulting request never reaches the bus, so its lanes are not loaded.
        if (!w_fault) begin
          r_mem_we    <= req_store;
          r_mem_be    <= w_be;
          r_mem_addr  <= w_maddr;
          r_mem_wdata <= w_wdata;
        end
      end
      if (w_capture) begin
        r_rdata <= r_store ? '0 : w_load;
      end
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rsp_rdata = r_rdata;
  assign rsp_fault = r_fault;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: one XLEN=32 and one XLEN=64 instance
// share stimulus; sel64 picks which one is driven and observed.
module tb_mem_access_unit;
  logic        clk;
  logic        rst_n;
  logic        sel64;
  logic        req_valid;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [63:0] mem_rdata;
  logic        rsp_ready;

  logic        rr32, mrv32, we32, rv32, f32;
  logic [3:0]  be32;
  logic [31:0] ma32, wd32, rd32;
  logic        rr64, mrv64, we64, rv64, f64;
  logic [7:0]  be64;
  logic [31:0] ma64;
  logic [63:0] wd64, rd64;

  int n_cmp = 0;
  int n_err = 0;

  mem_access_unit #(.XLEN(32), .ADDR_W(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid & ~sel64), .req_ready(rr32),
    .req_store(req_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .mem_req_valid(mrv32), .mem_req_ready(mem_req_ready),
    .mem_we(we32), .mem_be(be32), .mem_addr(ma32), .mem_wdata(wd32),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata[31:0]),
    .rsp_valid(rv32), .rsp_ready(rsp_ready),
    .rsp_rdata(rd32), .rsp_fault(f32)
  );

  mem_access_unit #(.XLEN(64), .ADDR_W(32)) u_dut64 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid & sel64), .req_ready(rr64),
    .req_store(req_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req_valid(mrv64), .mem_req_ready(mem_req_ready),
    .mem_we(we64), .mem_be(be64), .mem_addr(ma64), .mem_wdata(wd64),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .rsp_valid(rv64), .rsp_ready(rsp_ready),
    .rsp_rdata(rd64), .rsp_fault(f64)
  );

  logic        o_req_ready, o_mem_req_valid, o_mem_we, o_rsp_valid, o_rsp_fault;
  logic [7:0]  o_mem_be;
  logic [31:0] o_mem_addr;
  logic [63:0] o_mem_wdata, o_rsp_rdata;

  assign o_req_ready     = sel64 ? rr64  : rr32;
  assign o_mem_req_valid = sel64 ? mrv64 : mrv32;
  assign o_mem_we        = sel64 ? we64  : we32;
  assign o_mem_be        = sel64 ? be64  : {4'h0, be32};
  assign o_mem_addr      = sel64 ? ma64  : ma32;
  assign o_mem_wdata     = sel64 ? wd64  : {32'h0, wd32};
  assign o_rsp_valid     = sel64 ? rv64  : rv32;
  assign o_rsp_rdata     = sel64 ? rd64  : {32'h0, rd32};
  assign o_rsp_fault     = sel64 ? f64   : f32;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full non-faulting transaction with optional memory and response stalls.
  task automatic txn(input string tag, input bit x64, input bit st, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                     input logic [7:0] e_be, input logic [63:0] e_wdata,
                     input logic [63:0] e_rdata, input int mstall, input int rstall);
    logic [31:0] e_addr;
    e_addr     = addr & (x64 ? 32'hFFFF_FFF8 : 32'hFFFF_FFFC);
    sel64      = x64;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    #1;
    check({tag, ".req_ready"}, o_req_ready, 1);
    step();
    req_valid = 1'b0;
    for (int i = 0; i <= mstall; i++) begin
      check({tag, ".mem_req_valid"}, o_mem_req_valid, 1);
      check({tag, ".mem_we"}, o_mem_we, st);
      check({tag, ".mem_be"}, o_mem_be, e_be);
      check({tag, ".mem_addr"}, o_mem_addr, e_addr);
      check({tag, ".mem_wdata"}, o_mem_wdata, e_wdata);
      if (i == mstall) mem_req_ready = 1'b1;
      step();
    end
    mem_req_ready = 1'b0;
    check({tag, ".wait_mem_req_valid"}, o_mem_req_valid, 0);
    check({tag, ".wait_rsp_valid"}, o_rsp_valid, 0);
    mem_rsp_valid = 1'b1;
    mem_rdata     = rd;
    step();
    mem_rsp_valid = 1'b0;
    for (int i = 0; i <= rstall; i++) begin
      check({tag, ".rsp_valid"}, o_rsp_valid, 1);
      check({tag, ".rsp_rdata"}, o_rsp_rdata, e_rdata);
      check({tag, ".rsp_fault"}, o_rsp_fault, 0);
      check({tag, ".resp_req_ready"}, o_req_ready, 0);
      if (i == rstall) rsp_ready = 1'b1;
      step();
    end
    rsp_ready = 1'b0;
    check({tag, ".done_rsp_valid"}, o_rsp_valid, 0);
    check({tag, ".done_req_ready"}, o_req_ready, 1);
  endtask

  task automatic fault_txn(input string tag, input bit x64, input bit st,
                           input logic [2:0] f3, input logic [31:0] addr);
    sel64      = x64;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = 64'hFFFF_FFFF_FFFF_FFFF;
    req_valid  = 1'b1;
    step();
    req_valid = 1'b0;
    check({tag, ".mem_req_valid"}, o_mem_req_valid, 0);
    check({tag, ".rsp_valid"}, o_rsp_valid, 1);
    check({tag, ".rsp_fault"}, o_rsp_fault, 1);
    check({tag, ".rsp_rdata"}, o_rsp_rdata, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({tag, ".after_mem_req_valid"}, o_mem_req_valid, 0);
    check({tag, ".after_rsp_valid"}, o_rsp_valid, 0);
  endtask

  task automatic reset_outputs(input string tag);
    check({tag, ".mem_req_valid"}, o_mem_req_valid, 0);
    check({tag, ".rsp_valid"}, o_rsp_valid, 0);
    check({tag, ".rsp_fault"}, o_rsp_fault, 0);
    check({tag, ".rsp_rdata"}, o_rsp_rdata, 0);
    check({tag, ".mem_we"}, o_mem_we, 0);
    check({tag, ".mem_be"}, o_mem_be, 0);
    check({tag, ".mem_addr"}, o_mem_addr, 0);
    check({tag, ".mem_wdata"}, o_mem_wdata, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    sel64         = 1'b0;
    req_valid     = 1'b0;
    req_store     = 1'b0;
    req_funct3    = 3'b000;
    req_addr      = '0;
    req_wdata     = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;
    rsp_ready     = 1'b0;

    #12;
    reset_outputs("rst32");
    sel64 = 1'b1;
    #1;
    reset_outputs("rst64");
    sel64 = 1'b0;
    rst_n = 1'b1;
    step();
    check("rst32.req_ready", o_req_ready, 1);

    // XLEN=32 loads and stores
    txn("lb32",  0, 0, 3'b000, 32'h1003, 64'h0, 64'h8012_3456,
        8'h08, 64'h0, 64'hFFFF_FF80, 0, 0);
    txn("lhu32", 0, 0, 3'b101, 32'h2002, 64'h0, 64'hBEEF_1234,
        8'h0C, 64'h0, 64'h0000_BEEF, 0, 0);
    txn("sb32",  0, 1, 3'b000, 32'h4002, 64'hAB, 64'hDEAD_BEEF,
        8'h04, 64'h00AB_0000, 64'h0, 3, 2);
    txn("sh32",  0, 1, 3'b001, 32'h4002, 64'hFFFF_CAFE, 64'h0,
        8'h0C, 64'hCAFE_0000, 64'h0, 0, 1);
    txn("lw32",  0, 0, 3'b010, 32'h5000, 64'h0, 64'h89AB_CDEF,
        8'h0F, 64'h0, 64'h89AB_CDEF, 0, 0);
    txn("lbu32", 0, 0, 3'b100, 32'h5001, 64'h0, 64'h89AB_CDEF,
        8'h02, 64'h0, 64'h0000_00CD, 1, 0);

    // XLEN=32 faults
    fault_txn("sh_mis32",  0, 1, 3'b001, 32'h3001);
    fault_txn("ld32",      0, 0, 3'b011, 32'h0000);
    fault_txn("lwu32",     0, 0, 3'b110, 32'h0000);
    fault_txn("f3_111_32", 0, 0, 3'b111, 32'h0000);
    fault_txn("sbu32",     0, 1, 3'b100, 32'h0000);
    fault_txn("lw_mis32",  0, 0, 3'b010, 32'h5002);

    // XLEN=64 loads and stores
    txn("lwu64", 1, 0, 3'b110, 32'h8004, 64'h0, 64'hF000_0001_0000_0000,
        8'hF0, 64'h0, 64'h0000_0000_F000_0001, 0, 0);
    txn("lw64",  1, 0, 3'b010, 32'h8004, 64'h0, 64'hF000_0001_0000_0000,
        8'hF0, 64'h0, 64'hFFFF_FFFF_F000_0001, 0, 0);
    txn("ld64",  1, 0, 3'b011, 32'h8008, 64'h0, 64'h0123_4567_89AB_CDEF,
        8'hFF, 64'h0, 64'h0123_4567_89AB_CDEF, 1, 0);
    txn("lh64",  1, 0, 3'b001, 32'h8006, 64'h0, 64'h8001_0000_0000_0000,
        8'hC0, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 0, 0);
    txn("sb64",  1, 1, 3'b000, 32'h8007, 64'h5A, 64'h1234,
        8'h80, 64'h5A00_0000_0000_0000, 64'h0, 0, 0);
    txn("sd64",  1, 1, 3'b011, 32'h8000, 64'h1122_3344_5566_7788, 64'h0,
        8'hFF, 64'h1122_3344_5566_7788, 64'h0, 0, 0);

    // XLEN=64 faults
    fault_txn("ld_mis64", 1, 0, 3'b011, 32'h8004);
    fault_txn("swu64",    1, 1, 3'b110, 32'h8000);
    fault_txn("f3_111_64", 1, 0, 3'b111, 32'h8000);

    // Reset while waiting on memory abandons the transaction
    sel64      = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h6004;
    req_wdata  = 64'h0;
    req_valid  = 1'b1;
    step();
    req_valid     = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    check("rstw.pre_mem_be", o_mem_be, 8'h0F);
    check("rstw.pre_mem_addr", o_mem_addr, 32'h6004);
    #2;
    rst_n = 1'b0;
    #1;
    reset_outputs("rstw");
    #2;
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 64'h7777_7777;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rstw.late_rsp_valid", o_rsp_valid, 0);
      check("rstw.late_mem_req_valid", o_mem_req_valid, 0);
    end
    mem_rsp_valid = 1'b0;
    check("rstw.req_ready", o_req_ready, 1);
    check("rstw.rsp_rdata", o_rsp_rdata, 0);

    txn("lw_after_rst", 0, 0, 3'b010, 32'h6008, 64'h0, 64'h0BAD_F00D,
        8'h0F, 64'h0, 64'h0BAD_F00D, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
